// File: rtl/param_burst_memory_if.sv
// Burst memory bus between the last-level cache (master) and the backing store (slave).
interface param_burst_memory_if #(
  parameter int BEAT_W = 64
);
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );
  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/param_burst_memory.sv
// Latency-accurate line-burst memory model with DRAM-style open-page hit/miss timing.
module param_burst_memory #(
  parameter int DELAY_MISS = 50,
  parameter int DELAY_HIT  = 25,
  parameter int BURST_LEN  = 4,
  parameter int LINE_BITS  = 256,
  parameter int PAGE_BYTES = 512,
  parameter int MEM_LINES  = 1024
) (
  input logic                 clk,
  input logic                 rst,
  param_burst_memory_if.slave bus
);
  localparam int BEAT_W = LINE_BITS / BURST_LEN;
  localparam int OFFS_W = $clog2(LINE_BITS / 8);
  localparam int IDX_W  = $clog2(MEM_LINES);
  localparam int PG_SH  = $clog2(PAGE_BYTES);
  localparam int PG_W   = 32 - PG_SH;
  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int CNT_W  = (DELAY_MISS > 1) ? $clog2(DELAY_MISS + 1) : 1;

  // Counter is loaded with D-1 so the first beat lands exactly D edges after acceptance.
  localparam logic [CNT_W-1:0]  HIT_LD   = CNT_W'(DELAY_HIT - 1);
  localparam logic [CNT_W-1:0]  MISS_LD  = CNT_W'(DELAY_MISS - 1);
  localparam logic [BCNT_W-1:0] LAST_BT  = BCNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] line;
    logic [PG_W-1:0]  page;
    logic             wr;
  } req_t;

  logic [BURST_LEN-1:0][BEAT_W-1:0] mem [MEM_LINES];

  state_t            state;
  req_t              req;
  logic [CNT_W-1:0]  cnt;
  logic [BCNT_W-1:0] beat;
  logic              resp_q;
  logic [BEAT_W-1:0] rdata_q;
  logic              open_vld;
  logic [PG_W-1:0]   open_page;
  logic [PG_W-1:0]   pg_in;
  logic              addr_unused;

  // Page is taken from the unwrapped address so aliased lines still miss.
  assign pg_in       = bus.mem_address[31:PG_SH];
  assign addr_unused = ^bus.mem_address[OFFS_W-1:0];
  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req       <= '0;
      cnt       <= '0;
      beat      <= '0;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
      open_vld  <= 1'b0;
      open_page <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.mem_read || bus.mem_write) begin
            req.line <= bus.mem_address[OFFS_W +: IDX_W];
            req.page <= pg_in;
            req.wr   <= !bus.mem_read;
            cnt      <= (open_vld && open_page == pg_in) ? HIT_LD : MISS_LD;
            beat     <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state  <= BURST;
            resp_q <= 1'b1;
            if (!req.wr) rdata_q <= mem[req.line][0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        BURST: begin
          if (beat == LAST_BT) begin
            resp_q    <= 1'b0;
            open_vld  <= 1'b1;
            open_page <= req.page;
            beat      <= '0;
            state     <= IDLE;
          end else begin
            beat <= beat + 1'b1;
            if (!req.wr) rdata_q <= mem[req.line][beat + 1'b1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; a reset mid-write leaves already-written beats in place.
  always_ff @(posedge clk) begin
    if (state == BURST && req.wr) mem[req.line][beat] <= bus.mem_wdata;
  end
endmodule

// File: tb/tb_param_burst_memory.sv
// Randomized and directed checks of param_burst_memory against a line-level reference model.
module tb_param_burst_memory;
  localparam int MEM_LINES = 1024;
  localparam int DMISS = 50;
  localparam int DHIT  = 25;

  typedef logic [3:0][63:0] line_t;

  logic clk;
  logic rst;
  param_burst_memory_if #(.BEAT_W(64)) bus ();

  param_burst_memory #(
    .DELAY_MISS(DMISS), .DELAY_HIT(DHIT), .BURST_LEN(4),
    .LINE_BITS(256), .PAGE_BYTES(512), .MEM_LINES(MEM_LINES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  line_t       model [MEM_LINES];
  bit          known [MEM_LINES];
  bit          pg_vld;
  logic [31:0] open_pg;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; expected latency and data come from the page/line model.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr, input line_t wd,
                     input bit early, output int lat);
    int          line;
    logic [31:0] pg;
    int          exp_lat;
    line_t       exp_line;
    line    = int'((addr >> 5) % MEM_LINES);
    pg      = addr / 512;
    exp_lat = (pg_vld && pg == open_pg) ? DHIT : DMISS;
    exp_line = model[line];
    @(negedge clk);
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.mem_address = addr;
    bus.mem_wdata   = {$urandom, $urandom};
    @(posedge clk);
    #1;
    if (early) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
    end
    lat = 0;
    while (bus.mem_resp !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    for (int i = 0; i < 4; i++) begin
      chk("resp_beat", 64'(bus.mem_resp), 64'(1));
      if (rd) chk("rdata", bus.mem_rdata, exp_line[i]);
      else    bus.mem_wdata = wd[i];
      @(posedge clk);
      #1;
    end
    chk("resp_end", 64'(bus.mem_resp), 64'(0));
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    if (!rd) begin
      model[line] = wd;
      known[line] = 1'b1;
    end
    pg_vld  = 1'b1;
    open_pg = pg;
  endtask

  function automatic line_t rnd_line();
    line_t l;
    for (int i = 0; i < 4; i++) l[i] = {$urandom, $urandom};
    return l;
  endfunction

  initial begin
    int    lat;
    line_t l40, l60, l200, l80, la;
    line_t none;
    int    pgs [5];
    logic [31:0] addr;
    int    line;
    bit    rd;
    pgs = '{0, 1, 2, 64, 65};
    none = '0;
    pg_vld = 1'b0;
    open_pg = '0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp", 64'(bus.mem_resp), 64'(0));
    chk("rst_rdata", bus.mem_rdata, 64'(0));
    @(negedge clk);
    rst = 1'b1;

    l40  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    l60  = rnd_line();
    l200 = rnd_line();
    l80  = rnd_line();
    txn(0, 1, 32'h0000_0040, l40, 0, lat);
    chk("first_write_lat", 64'(lat), 64'(DMISS));
    txn(0, 1, 32'h0000_0060, l60, 0, lat);
    txn(0, 1, 32'h0000_0200, l200, 0, lat);
    txn(0, 1, 32'h0000_0080, l80, 0, lat);

    // Reset closes the page but keeps storage.
    @(negedge clk);
    rst = 1'b0;
    pg_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    txn(1, 0, 32'h0000_0040, none, 0, lat);
    chk("miss_lat", 64'(lat), 64'(DMISS));
    txn(1, 0, 32'h0000_0060, none, 0, lat);
    chk("hit_lat", 64'(lat), 64'(DHIT));
    txn(1, 0, 32'h0000_0200, none, 0, lat);
    chk("newpage_lat", 64'(lat), 64'(DMISS));

    la = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
          64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
    txn(0, 1, 32'h0000_1000, la, 0, lat);
    txn(1, 0, 32'h0000_1000, none, 0, lat);
    chk("wr_rd_hit_lat", 64'(lat), 64'(DHIT));
    txn(1, 0, 32'h0000_101F, none, 0, lat);
    chk("lowbit_hit_lat", 64'(lat), 64'(DHIT));
    txn(1, 0, 32'h0000_1000 + MEM_LINES * 32, none, 0, lat);
    chk("wrap_miss_lat", 64'(lat), 64'(DMISS));
    chk("wrap_model_line", model[128][0], 64'hAAAA_0000_0000_000A);

    txn(1, 1, 32'h0000_0080, rnd_line(), 0, lat);
    txn(1, 0, 32'h0000_0080, none, 0, lat);
    chk("rw_storage_kept", model[4][3], l80[3]);
    txn(1, 0, 32'h0000_0040, none, 1, lat);

    // Reset during beat 2 of a read drops resp without waiting for an edge.
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.mem_address = 32'h0000_0040;
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    lat = 0;
    while (bus.mem_resp !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("midrst_lat", 64'(lat), 64'(DHIT));
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_beat2", bus.mem_rdata, l40[2]);
    rst = 1'b0;
    #1;
    chk("midrst_resp", 64'(bus.mem_resp), 64'(0));
    chk("midrst_rdata", bus.mem_rdata, 64'(0));
    pg_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    txn(1, 0, 32'h0000_1000, none, 0, lat);
    chk("post_rst_lat", 64'(lat), 64'(DMISS));

    for (int k = 0; k < 30; k++) begin
      addr = 32'(pgs[$urandom_range(0, 4)] * 512) + 32'($urandom_range(0, 511));
      line = int'((addr >> 5) % MEM_LINES);
      rd = known[line] && ($urandom_range(0, 1) == 1);
      txn(rd, !rd || ($urandom_range(0, 3) == 0), addr, rnd_line(),
          $urandom_range(0, 3) == 0, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/param_burst_memory.md
Name: param_burst_memory

Overview:
- Parameterised, latency-accurate main-memory model with a burst interface and DRAM-style open-page timing.
- Serves cache-line-sized read/write requests as BURST_LEN consecutive beats.
- First-beat latency depends on whether the request hits the currently open page.
- Sits below the processor's last-level cache as the system backing store.

Parameters:
- DELAY_MISS, 50: cycles from request acceptance to first beat when the page is closed or different.
- DELAY_HIT, 25: cycles from request acceptance to first beat on an open-page hit.
- BURST_LEN, 4: beats per transaction.
- LINE_BITS, 256: bits per cache line. Beat width is LINE_BITS/BURST_LEN = 64.
- PAGE_BYTES, 512: DRAM page size in bytes, power of two.
- MEM_LINES, 1024: lines of storage, power of two. Addresses wrap modulo MEM_LINES.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request; hold until the last beat.
- mem_write  in  1  write request; hold until the last beat.
- mem_address  in  32  byte address; low log2(LINE_BITS/8)=5 bits ignored.
- mem_wdata  in  64  write beat data.
- mem_rdata  out  64  read beat data.
- mem_resp  out  1  beat valid strobe.

Behaviour:
- Reset (rst=0, asynchronous):
  - State=IDLE; mem_resp=0; mem_rdata=0; beat counter=0.
  - open_page invalid.
  - Storage contents are not cleared.
  - Reset mid-transaction aborts it. A partially written line keeps the beats already written.
- States: IDLE, WAIT, BURST.
- IDLE:
  - On a rising edge with mem_read or mem_write high, latch line index = address[31:5] mod MEM_LINES, page = address / PAGE_BYTES, and op.
  - Read wins if both are high.
  - Load latency D = DELAY_HIT if open_page is valid and equal to page, else DELAY_MISS.
  - Go to WAIT.
- WAIT: count down. The first beat's mem_resp is high in the cycle that begins exactly D rising edges after the acceptance edge. Then go to BURST.
- BURST:
  - mem_resp=1 for BURST_LEN consecutive cycles, beat i=0..BURST_LEN-1.
  - Beat i covers line bits [64i+63:64i] (beat 0 = least significant).
  - Read: mem_rdata = beat i of the latched line.
  - Write: mem_wdata is sampled on the rising edge that ends each resp cycle and stored into beat i.
  - After the last beat: mem_resp=0, open_page=page (valid), return to IDLE.
  - mem_rdata holds its last value outside BURST.
- Request lines are ignored after acceptance. Deasserting early does not abort; the transaction completes.
- The next request can be accepted no earlier than the first rising edge after the last beat's cycle (the edge where mem_resp falls).
- A request arriving during WAIT/BURST is not queued. It is accepted only if still asserted in IDLE.
- Page compare uses the full 32-bit address / PAGE_BYTES, before wrapping.
- Latency counters must support D >= 1. Parameters must satisfy DELAY_HIT <= DELAY_MISS.

Test Plan:
- Read miss: after reset, preload line 0x40 with beats 0x11..,0x22..,0x33..,0x44.., then read address 0x0000_0040 → mem_resp rises exactly 50 cycles after acceptance, stays high 4 cycles, and mem_rdata returns the beats in order.
- Page hit: immediately read 0x0000_0060 (same 512-byte page) → first beat after 25 cycles. Then read 0x0000_0200 (new page) → 50 cycles.
- Write/readback: write 0x0000_1000 with beats A,B,C,D → 4 resp cycles. Then read 0x0000_1000 → first beat after 25 cycles (page hit), returning A,B,C,D.
- Low-bit masking and wrap: read 0x0000_101F → same data as 0x0000_1000. Read 0x0000_1000 + MEM_LINES*32 → same data, with miss latency 50 cycles (different page).
- Simultaneous read+write to 0x80 → treated as read, storage unchanged. Early deassert of mem_read one cycle after acceptance → still 4 beats.
- Reset mid-burst: assert rst=0 during beat 2 of a read → mem_resp drops immediately (asynchronously). Next read of any address after release takes 50 cycles (page closed).
